line_mem_responder: RTL

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/dmc_pkg.sv | 23 ++
 rtl/line_mem_responder_if.sv | 31 +++
 rtl/line_mem_array.sv | 40 ++++
 rtl/line_mem_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/dmc_pkg.sv
// Shared definitions for the direct-mapped cache controller and its line memory.
// Holds the responder state encoding and the default line geometry.
package dmc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    localparam int unsigned DMC_BLOCKS_PER_LINE = 2;
    localparam int unsigned DMC_MEM_ADDR_BITS   = 8;
    localparam int unsigned DMC_OFFSET_BITS     = $clog2(DMC_BLOCKS_PER_LINE);
    localparam int unsigned DMC_INDEX_BITS      = DMC_MEM_ADDR_BITS - DMC_OFFSET_BITS;

    // Counter width able to index n items; never narrower than one bit.
    function automatic int unsigned counter_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Request / write-beat / read-beat bundle between cache controller and line memory.
// The controller side uses master, the responder side uses slave.
interface line_mem_responder_if #(
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned BLOCK_SIZE   = 4
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_write_i;
    logic [ADDRESS_SIZE-1:0] req_address_i;
    logic                    wdata_valid_i;
    logic [BLOCK_SIZE-1:0]   wdata_i;
    logic                    wdata_ready_o;
    logic                    rdata_valid_o;
    logic [BLOCK_SIZE-1:0]   rdata_o;
    logic                    rdata_last_o;
    logic                    done_o;
    logic                    busy_o;

    modport master (
        output req_valid_i, req_write_i, req_address_i, wdata_valid_i, wdata_i,
        input  req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
               done_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_address_i, wdata_valid_i, wdata_i,
        output req_ready_o, wdata_ready_o, rdata_valid_o, rdata_o, rdata_last_o,
               done_o, busy_o
    );
endinterface

// File: rtl/line_mem_array.sv
// Block-wide backing store: synchronous write, combinational read.
// The single write port is shared by the responder FSM and the backdoor preload.
module line_mem_array #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 fsm_we_i,
    input  logic [ADDR_BITS-1:0] fsm_addr_i,
    input  logic [WIDTH-1:0]     fsm_data_i,
    input  logic                 pl_we_i,
    input  logic [ADDR_BITS-1:0] pl_addr_i,
    input  logic [WIDTH-1:0]     pl_data_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);
    logic [WIDTH-1:0]     mem_q [2**ADDR_BITS];
    logic                 we;
    logic [ADDR_BITS-1:0] waddr;
    logic [WIDTH-1:0]     wdata;

    always_comb begin
        we    = fsm_we_i;
        waddr = fsm_addr_i;
        wdata = fsm_data_i;
        if (pl_we_i) begin
            we    = 1'b1;
            waddr = pl_addr_i;
            wdata = pl_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/line_mem_responder.sv
// Line-granular memory model answering cache fills (read bursts) and flushes
// (write bursts), with a programmable read latency and a backdoor preload port.
module line_mem_responder
    import dmc_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE             = 4,
    parameter int unsigned NUM_OF_BLOCKS_PER_LINE = 2,
    parameter int unsigned ADDRESS_SIZE           = 16,
    parameter int unsigned MEM_ADDR_BITS          = 8,
    parameter int unsigned READ_LATENCY           = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    line_mem_responder_if.slave     bus,
    input  logic                    preload_we_i,
    input  logic [ADDRESS_SIZE-1:0] preload_address_i,
    input  logic [BLOCK_SIZE-1:0]   preload_data_i
);
    localparam int unsigned BEAT_W = counter_width(NUM_OF_BLOCKS_PER_LINE);
    localparam int unsigned WAIT_W = counter_width(READ_LATENCY + 1);
    localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(NUM_OF_BLOCKS_PER_LINE - 1);
    localparam logic [WAIT_W-1:0]        LAST_WAIT = WAIT_W'(READ_LATENCY - 1);
    localparam logic [MEM_ADDR_BITS-1:0] LINE_MASK = ~MEM_ADDR_BITS'(NUM_OF_BLOCKS_PER_LINE - 1);

    state_t                   state_q;
    logic [MEM_ADDR_BITS-1:0] base_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [WAIT_W-1:0]        wait_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     rvalid_q;
    logic                     rlast_q;
    logic                     wready_q;
    logic                     done_q;
    logic [BLOCK_SIZE-1:0]    rdata_q;

    logic [MEM_ADDR_BITS-1:0] req_base;
    logic [BEAT_W-1:0]        next_beat;
    logic                     req_ready;
    logic                     accept;
    logic [MEM_ADDR_BITS-1:0] rd_addr;
    logic [BLOCK_SIZE-1:0]    rd_data;
    logic                     fsm_we;
    logic [MEM_ADDR_BITS-1:0] fsm_waddr;
    logic                     pl_we;

    assign req_base  = bus.req_address_i[MEM_ADDR_BITS-1:0] & LINE_MASK;
    assign next_beat = beat_q + 1'b1;
    assign req_ready = ready_q && (state_q == IDLE) && !preload_we_i;
    assign accept    = bus.req_valid_i && req_ready;

    // Read data is registered, so the array is addressed one beat ahead of
    // what is currently presented on rdata_o.
    always_comb begin
        rd_addr = req_base;
        if (state_q == RD_WAIT) begin
            rd_addr = base_q;
        end else if (state_q == RD_BURST) begin
            rd_addr = base_q | MEM_ADDR_BITS'(next_beat);
        end
    end

    assign fsm_we    = (state_q == WR_BURST) && bus.wdata_valid_i && !rst_i;
    assign fsm_waddr = base_q | MEM_ADDR_BITS'(beat_q);
    assign pl_we     = (state_q == IDLE) && preload_we_i;

    line_mem_array #(
        .WIDTH     (BLOCK_SIZE),
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_array (
        .clk_i      (clk_i),
        .fsm_we_i   (fsm_we),
        .fsm_addr_i (fsm_waddr),
        .fsm_data_i (bus.wdata_i),
        .pl_we_i    (pl_we),
        .pl_addr_i  (preload_address_i[MEM_ADDR_BITS-1:0]),
        .pl_data_i  (preload_data_i),
        .raddr_i    (rd_addr),
        .rdata_o    (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            base_q   <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            wready_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        base_q  <= req_base;
                        beat_q  <= '0;
                        wait_q  <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.req_write_i) begin
                            state_q  <= WR_BURST;
                            wready_q <= 1'b1;
                        end else if (READ_LATENCY == 0) begin
                            state_q  <= RD_BURST;
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_data;
                            rlast_q  <= (LAST_BEAT == '0);
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (wait_q == LAST_WAIT) begin
                        state_q  <= RD_BURST;
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data;
                        rlast_q  <= (LAST_BEAT == '0);
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                RD_BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        state_q  <= DONE;
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        beat_q  <= next_beat;
                        rdata_q <= rd_data;
                        rlast_q <= (next_beat == LAST_BEAT);
                    end
                end
                WR_BURST: begin
                    if (bus.wdata_valid_i) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q  <= DONE;
                            wready_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            beat_q <= next_beat;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.busy_o        = busy_q;
    assign bus.rdata_valid_o = rvalid_q;
    assign bus.rdata_o       = rdata_q;
    assign bus.rdata_last_o  = rlast_q;
    assign bus.wdata_ready_o = wready_q;
    assign bus.done_o        = done_q;
endmodule
